// File: rtl/mod_n_counter.sv
// mod_n_counter: synchronous modulo-N up/down counter with parallel load,
// terminal-count strobe and a toggle divider output.
// Every state bit moves on the same rising clk edge, so there is no ripple skew.
// The modulus, direction and enable are sampled live on every edge, with no pipeline.
module mod_n_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             div_tog
);

  logic [WIDTH-1:0] r_count;
  logic             r_div_tog;
  logic [WIDTH-1:0] w_last;
  logic [WIDTH-1:0] w_count_next;
  logic             w_at_terminal;
  logic             w_tc;
  logic             w_out_of_range;

  // A modulus of 0 means 2^WIDTH. Subtracting 1 in WIDTH bits wraps 0 to
  // all ones, so that case needs no special logic.
  assign w_last = modulus - 1'b1;

  // A count above Last can only occur after the modulus has been lowered at runtime.
  assign w_out_of_range = (r_count > w_last);

  // The terminal value depends on the direction: Last when counting up, 0 when
  // counting down. An out-of-range count never matches either value.
  assign w_at_terminal = up ? (r_count == w_last) : (r_count == '0);

  // The strobe fires only on an enabled step with no load. It is held low while
  // Rst is asserted, because the count of 0 would otherwise look terminal when counting down.
  assign w_tc = en & ~load & ~Rst & w_at_terminal;

  // Next-count selection. Load has priority over enable. Without either, the count holds.
  always_comb begin
    w_count_next = r_count;
    if (load) begin
      // Clip the loaded value into range, so the count never exceeds Last.
      w_count_next = (load_val > w_last) ? w_last : load_val;
    end else if (en) begin
      if (up) begin
        w_count_next = (r_count == w_last || w_out_of_range) ? '0 : r_count + 1'b1;
      end else begin
        w_count_next = (r_count == '0 || w_out_of_range) ? w_last : r_count - 1'b1;
      end
    end
  end

  // Count and divider state. Reset clears both immediately, with no resume.
  // The divider inverts on every terminal strobe, giving a 50% duty output at f_clk/(2*Meff).
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_count   <= '0;
      r_div_tog <= 1'b0;
    end else begin
      r_count <= w_count_next;
      if (w_tc) begin
        r_div_tog <= ~r_div_tog;
      end
    end
  end

  assign count   = r_count;
  assign div_tog = r_div_tog;
  assign tc      = w_tc;

endmodule

// File: doc/mod_n_counter.md
# mod_n_counter

Parametrised synchronous modulo-N counter and clock divider: the next generation of the team's fixed 3-stage toggle-flop ripple counter. All state moves on a single clock edge, so there is no ripple skew between bits. The block adds runtime modulus, up/down direction, count enable, parallel load, a terminal-count strobe and a toggle divider output. It serves as the general counter/divider primitive for the counters-and-dividers library.

## Interface
- WIDTH, 8, counter width in bits (≥ 1).
- clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; when low, the count holds.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value used on load.
- modulus  input  WIDTH  count modulus M; 0 encodes 2^WIDTH.
- count  output  WIDTH  registered count value.
- tc  output  1  terminal-count strobe (combinational from count, en, up, modulus).
- div_tog  output  1  registered divider output; toggles on every wrap.

## Operation
- Effective modulus: Meff = modulus, or 2^WIDTH when modulus == 0. Last = Meff − 1, computed in WIDTH bits (all ones when modulus == 0).
- Priority on each rising edge: Rst > load > en > hold.
- Load: count ← load_val if load_val ≤ Last, otherwise Last. div_tog is unchanged. Load takes effect regardless of en.
- Enabled up step: if count == Last or count > Last, count ← 0. Otherwise count ← count + 1.
- Enabled down step: if count == 0 or count > Last, count ← Last. Otherwise count ← count − 1.
- Out-of-range count (> Last, which happens only after modulus is lowered) recovers in one enabled step and asserts no tc.
- tc = en & ~load & (up ? count == Last : count == 0). Only the exact terminal value asserts tc.
- div_tog inverts on every edge where tc is high. Output frequency is f_clk / (2·Meff) when en is held high. Duty is exactly 50%.
- Meff = 1: count stays 0 and tc = en. div_tog toggles on every enabled edge, giving f_clk/2.
- modulus and up may change on any cycle. They take effect on the next edge with no pipeline.

## Timing
- Reset values, applied immediately on Rst rising and held while Rst is high: count = 0, div_tog = 0. tc = 0 while Rst is high.
- Rst deassertion is asynchronous to the block. The first counting edge is the first rising clk after Rst falls.
- A reset arriving mid-count discards the count and the divider phase. There is no resume.
- Latency: count and div_tog change one clk after the qualifying inputs. tc is valid in the same cycle as count, and is combinational from the registered count plus live inputs.
- Simultaneous load and en: load wins, tc is suppressed and div_tog holds.
- Simultaneous up change and terminal: the wrap follows the up value present at that edge.
- Wrap-around is modular. There is no sticky overflow flag, and the count never exceeds Last after one enabled step.

## Test plan
- Reset and up-count, WIDTH=8, modulus=5, en=1, up=1: count 0,1,2,3,4,0,1… tc is high only at count=4. div_tog toggles every 5 clks, period 10 clks. Assert Rst mid-sequence: count=0 and div_tog=0 immediately, with no clk edge needed.
- Down-count, modulus=5, up=0, starting from reset: count 0,4,3,2,1,0,4… tc is high only at count=0 with en=1. Drop en for 3 cycles: count holds, tc=0, div_tog holds.
- Load and clipping, modulus=10: load_val=7 → count=7 next edge. load_val=200 → count=9. load with en=1 at count=9 (up): no tc, div_tog unchanged, count=load value.
- Modulus edge cases: modulus=1 → count stays 0, tc=en, div_tog toggles every edge. modulus=0 with WIDTH=4 → full 0..15 wrap, tc at 15 (up) and at 0 (down).
- Runtime modulus shrink: count=12 with modulus=16, then set modulus=6. Next enabled up edge → count=0 with no tc. With up=0 instead → count=5.
- Direction reversal at terminal: modulus=8, count=7, up switched to 0 on that cycle: tc=0, next count=6, div_tog unchanged.
